// File: rtl/instr_pkg.sv
// Shared encoder/decoder constants: internal opcodes, ARM data-processing
// op codes, instruction field positions and the ALU sub-op lookup.
package instr_pkg;

  // Internal 7-bit opcodes (decoder encoding)
  localparam logic [6:0] OPC_MOVI  = 7'b0000000;
  localparam logic [6:0] OPC_HALT  = 7'b0000001;
  localparam logic [6:0] OPC_ADDI  = 7'b0001000;
  localparam logic [6:0] OPC_SUBI  = 7'b0001001;
  localparam logic [6:0] OPC_CMPI  = 7'b0001010;
  localparam logic [6:0] OPC_ANDI  = 7'b0001011;
  localparam logic [6:0] OPC_ORRI  = 7'b0001100;
  localparam logic [6:0] OPC_EORI  = 7'b0001101;
  localparam logic [6:0] OPC_MOVR  = 7'b0010000;
  localparam logic [6:0] OPC_MOVRS = 7'b0110000;
  localparam logic [6:0] OPC_B     = 7'b1000000;
  localparam logic [6:0] OPC_BX    = 7'b1000001;
  localparam logic [6:0] OPC_BL    = 7'b1000100;
  localparam logic [6:0] OPC_BLX   = 7'b1000101;

  // Upper opcode nibble selecting the ALU class; low 3 bits are the sub-op
  localparam logic [3:0] CLS_ALU_IMM = 4'b0001;
  localparam logic [3:0] CLS_ALU_REG = 4'b0011;
  localparam logic [3:0] CLS_ALU_RSH = 4'b0111;
  localparam logic [2:0] PPP_CMP     = 3'b010;

  // ARM data-processing op field
  localparam logic [3:0] ARM_AND = 4'b0000;
  localparam logic [3:0] ARM_EOR = 4'b0001;
  localparam logic [3:0] ARM_SUB = 4'b0010;
  localparam logic [3:0] ARM_ADD = 4'b0100;
  localparam logic [3:0] ARM_CMP = 4'b1010;
  localparam logic [3:0] ARM_ORR = 4'b1100;
  localparam logic [3:0] ARM_MOV = 4'b1101;

  // Field positions in the 32-bit word
  localparam int COND_LSB = 28;
  localparam int OP_LSB   = 21;
  localparam int S_BIT    = 20;
  localparam int RN_LSB   = 16;
  localparam int RD_LSB   = 12;
  localparam int RS_LSB   = 8;
  localparam int RM_LSB   = 0;

  typedef struct packed {
    logic       ok;
    logic [3:0] op;
  } alu_dec_t;

  // Map the 3-bit ALU sub-op to the ARM op field; 110/111 are unsupported
  function automatic alu_dec_t alu_op(input logic [2:0] ppp);
    alu_dec_t r;
    r.ok = 1'b1;
    case (ppp)
      3'b000:  r.op = ARM_ADD;
      3'b001:  r.op = ARM_SUB;
      3'b010:  r.op = ARM_CMP;
      3'b011:  r.op = ARM_AND;
      3'b100:  r.op = ARM_ORR;
      3'b101:  r.op = ARM_EOR;
      default: begin r.op = ARM_AND; r.ok = 1'b0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake plus instruction-memory write bus.
// slave: the encoder; master: the loader / memory side.
interface instr_encoder_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        cond;
  logic [6:0]        opcode;
  logic              en_status;
  logic [3:0]        rn, rd, rs, rm;
  logic [1:0]        shift_op;
  logic [4:0]        imm5;
  logic [11:0]       imm12;
  logic [23:0]       imm24;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport slave (
    input  in_valid, cond, opcode, en_status, rn, rd, rs, rm,
           shift_op, imm5, imm12, imm24, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, cond, opcode, en_status, rn, rd, rs, rm,
           shift_op, imm5, imm12, imm24, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_word_build.sv
// Combinational field -> 32-bit ARM word builder. Unsupported opcodes
// produce a HALT word with the caller's cond and raise illegal.
module instr_word_build
  import instr_pkg::*;
(
  input  logic [3:0]  cond,
  input  logic [6:0]  opcode,
  input  logic        en_status,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs,
  input  logic [3:0]  rm,
  input  logic [1:0]  shift_op,
  input  logic [4:0]  imm5,
  input  logic [11:0] imm12,
  input  logic [23:0] imm24,
  output logic [31:0] word,
  output logic        illegal
);

  alu_dec_t   alu;
  logic       s_alu;
  logic [3:0] cls;
  logic [31:0] halt_w;

  assign alu    = alu_op(opcode[2:0]);
  assign cls    = opcode[6:3];
  // CMP always sets flags
  assign s_alu  = en_status | (opcode[2:0] == PPP_CMP);
  assign halt_w = {cond, 7'b0001000, 21'b0};

  // Select the layout by opcode class
  always_comb begin
    word    = halt_w;
    illegal = 1'b0;
    if (opcode == OPC_MOVI)
      word = {cond, 3'b001, ARM_MOV, en_status, rn, rd, imm12};
    else if (opcode == OPC_HALT)
      word = halt_w;
    else if (cls == CLS_ALU_IMM && alu.ok)
      word = {cond, 3'b001, alu.op, s_alu, rn, rd, imm12};
    else if (cls == CLS_ALU_REG && alu.ok)
      word = {cond, 3'b000, alu.op, s_alu, rn, rd, imm5, shift_op, 1'b0, rm};
    else if (cls == CLS_ALU_RSH && alu.ok)
      word = {cond, 3'b000, alu.op, s_alu, rn, rd, rs, 1'b0, shift_op, 1'b1, rm};
    else if (opcode == OPC_MOVR)
      word = {cond, 3'b000, ARM_MOV, en_status, rn, rd, imm5, shift_op, 1'b0, rm};
    else if (opcode == OPC_MOVRS)
      word = {cond, 3'b000, ARM_MOV, en_status, rn, rd, rs, 1'b0, shift_op, 1'b1, rm};
    else if (opcode == OPC_B)
      word = {cond, 4'b1010, imm24};
    else if (opcode == OPC_BL)
      word = {cond, 4'b1011, imm24};
    else if (opcode == OPC_BX)
      word = {cond, 8'b00010010, 12'hFFF, 4'b0001, rm};
    else if (opcode == OPC_BLX)
      word = {cond, 8'b00010010, 12'hFFF, 4'b0011, rm};
    else
      illegal = 1'b1;
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: encodes field bundles and writes them to sequential
// instruction-memory addresses through a single valid/ready output register.
// Optional feature macro INSTR_ENC_FULL_STOP_EN: stop accepting once DEPTH
// words are written (no wrap) and flag full.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              full
);

  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W+1:0] DEPTH_C = (ADDR_W+2)'(DEPTH);

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [31:0]       word;
  logic              illegal;
  logic              in_ready;
  logic              accept;
  logic              done;

  instr_word_build u_build (
    .cond      (bus.cond),
    .opcode    (bus.opcode),
    .en_status (bus.en_status),
    .rn        (bus.rn),
    .rd        (bus.rd),
    .rs        (bus.rs),
    .rm        (bus.rm),
    .shift_op  (bus.shift_op),
    .imm5      (bus.imm5),
    .imm12     (bus.imm12),
    .imm24     (bus.imm24),
    .word      (word),
    .illegal   (illegal)
  );

`ifdef INSTR_ENC_FULL_STOP_EN
  logic            full_q, full_d;
  logic [ADDR_W+1:0] loaded;
  // Words already written plus the one pending in the output register
  assign loaded   = {1'b0, count_q} + (ADDR_W+2)'(wr_en_q);
  assign in_ready = !start && (!wr_en_q || bus.wr_ready) && !full_q && (loaded < DEPTH_C);
  assign full     = full_q;
`else
  assign in_ready = !start && (!wr_en_q || bus.wr_ready);
  assign full     = 1'b0;
`endif

  assign accept = bus.in_valid && in_ready;
  assign done   = wr_en_q && bus.wr_ready;

  // Next-state: start flush, write completion, new load
  always_comb begin
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    nxt_addr_d = nxt_addr_q;
    wr_data_d  = wr_data_q;
    count_d    = count_q;
    err_d      = err_q;
`ifdef INSTR_ENC_FULL_STOP_EN
    full_d     = full_q;
`endif
    if (start) begin
      nxt_addr_d = base_addr;
      count_d    = '0;
      err_d      = 1'b0;
      wr_en_d    = 1'b0;
`ifdef INSTR_ENC_FULL_STOP_EN
      full_d     = 1'b0;
`endif
    end else begin
      if (done) begin
        wr_en_d = 1'b0;
        if (count_q != '1) count_d = count_q + 1'b1;
      end
      if (accept) begin
        wr_en_d    = 1'b1;
        wr_addr_d  = nxt_addr_q;
        wr_data_d  = word;
        err_d      = err_q | illegal;
        nxt_addr_d = (nxt_addr_q == LAST_A) ? '0 : nxt_addr_q + 1'b1;
      end
`ifdef INSTR_ENC_FULL_STOP_EN
      if ({1'b0, count_d} >= DEPTH_C) full_d = 1'b1;
`endif
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      nxt_addr_q <= '0;
      wr_data_q  <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
`ifdef INSTR_ENC_FULL_STOP_EN
      full_q     <= 1'b0;
`endif
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      nxt_addr_q <= nxt_addr_d;
      wr_data_q  <= wr_data_d;
      count_q    <= count_d;
      err_q      <= err_d;
`ifdef INSTR_ENC_FULL_STOP_EN
      full_q     <= full_d;
`endif
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign count        = count_q;
  assign err          = err_q;

endmodule
